// File: rtl/axis_out_fifo.sv
// axis_out_fifo: buffers a no-backpressure AXI-Stream from the filter and
// re-presents it as a full AXI-Stream master. The head beat is held in an
// output register, so the output is first-word-fall-through. Debug outputs
// report the fill level, almost-full, delivered frames and sticky overflow.
module axis_out_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DATA_W-1:0]          s_axis_tdata_i,
    input  logic                       s_axis_tvalid_i,
    input  logic                       s_axis_tlast_i,
    output logic [DATA_W-1:0]          m_axis_tdata_o,
    output logic                       m_axis_tvalid_o,
    input  logic                       m_axis_tready_i,
    output logic                       m_axis_tlast_o,
    output logic                       s_afull_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [15:0]                frames_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    // Storage word is {tlast, tdata}; the head beat lives in word_q, the
    // remaining beats live in mem.
    logic [DATA_W:0] mem [DEPTH];

    state_t          state_q,  state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [DATA_W:0] word_q,   word_d;
    logic            afull_q,  afull_d;
    logic [15:0]     frames_q, frames_d;
    logic            ovf_q,    ovf_d;

    logic            pop;
    logic            accept;
    logic            ram_wr;
    logic [CW-1:0]   ram_cnt;
    logic [DATA_W:0] s_word;

    assign s_word = {s_axis_tlast_i, s_axis_tdata_i};

    // Next-state logic: output FSM, pointers, occupancy and debug counters.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        word_d   = word_q;
        frames_d = frames_q;
        ovf_d    = ovf_q;
        ram_wr   = 1'b0;

        pop    = (state_q == ST_VALID) && m_axis_tready_i;
        // At full, a same-cycle pop frees the slot the new beat needs.
        accept = s_axis_tvalid_i && ((count_q < CW'(DEPTH)) || pop);
        // Beats waiting in RAM behind the output register.
        ram_cnt = count_q - CW'(state_q == ST_VALID);

        case (state_q)
            ST_EMPTY: begin
                if (ram_cnt != '0) begin
                    word_d   = mem[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    state_d  = ST_VALID;
                end
                ram_wr = accept;
            end
            default: begin
                if (pop) begin
                    if (ram_cnt != '0) begin
                        word_d   = mem[rd_ptr_q];
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        ram_wr   = accept;
                    end else if (accept) begin
                        // Only beat is leaving and a new one arrives: refill
                        // straight from the input to avoid a bubble.
                        word_d = s_word;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else begin
                    ram_wr = accept;
                end
            end
        endcase

        if (ram_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        afull_d = (count_d >= CW'(AFULL_LVL));

        if (pop && word_q[DATA_W]) begin
            frames_d = frames_q + 16'd1;
        end

        if (s_axis_tvalid_i && !accept) begin
            ovf_d = 1'b1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            word_q   <= '0;
            afull_q  <= 1'b0;
            frames_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            word_q   <= word_d;
            afull_q  <= afull_d;
            frames_q <= frames_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array write port; contents need no reset since the
    // pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (ram_wr) begin
            mem[wr_ptr_q] <= s_word;
        end
    end

    assign m_axis_tvalid_o = (state_q == ST_VALID);
    assign m_axis_tdata_o  = word_q[DATA_W-1:0];
    assign m_axis_tlast_o  = word_q[DATA_W];
    assign s_afull_o       = afull_q;
    assign level_o         = count_q;
    assign frames_o        = frames_q;
    assign overflow_o      = ovf_q;

endmodule

// File: doc/axis_out_fifo.md
Name: axis_out_fifo

Overview:
- Output buffer stage directly downstream of the Gaussian filter.
- Filter output is an AXI-Stream without backpressure (tvalid/tdata/tlast, no tready); this block absorbs those beats into a synchronous FIFO.
- Re-presents them on a full AXI-Stream master with tready, so a stalling consumer (DMA, UART bridge) can sit behind the filter.
- Reports fill level, frames delivered and sticky overflow for debug.

Parameters:
- DATA_W, 8: tdata width in bits.
- DEPTH, 16: FIFO entries; power of two, minimum 4.
- AFULL_LVL, 12: s_afull_o asserts when level >= AFULL_LVL; valid range 1..DEPTH.

Ports:
- clk_i  in  1  system clock, same clock as the filter.
- rst_i  in  1  synchronous reset, active-high.
- s_axis_tdata_i  in  DATA_W  beat data from the filter.
- s_axis_tvalid_i  in  1  beat valid from the filter; no ready returned.
- s_axis_tlast_i  in  1  end-of-frame marker from the filter.
- m_axis_tdata_o  out  DATA_W  beat data to the consumer.
- m_axis_tvalid_o  out  1  output beat valid.
- m_axis_tready_i  in  1  consumer ready.
- m_axis_tlast_o  out  1  end-of-frame marker to the consumer.
- s_afull_o  out  1  almost-full flag.
- level_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- frames_o  out  16  count of tlast beats delivered on the master side; wraps 0xFFFF->0.
- overflow_o  out  1  sticky; set when an input beat is dropped.

Behaviour:
- Storage word is {tlast, tdata}, DATA_W+1 bits. Read/write pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy count is held separately.
- Reset (rst_i=1 at a clock edge) sets pointers=0, count=0, m_axis_tvalid_o=0, m_axis_tdata_o=0, m_axis_tlast_o=0, s_afull_o=0, level_o=0, frames_o=0, overflow_o=0.
- Reset mid-operation discards all buffered beats. No partial frame is emitted afterwards.
- Output is first-word-fall-through from a registered output stage. Data and tlast are driven from an output register, not directly from RAM.
- A beat accepted at edge N into an empty FIFO shows m_axis_tvalid_o=1 after edge N+1. Latency is 1 cycle.
- pop = m_axis_tvalid_o & m_axis_tready_i. On pop the next entry loads into the output register in the same edge. Back-to-back pops sustain 1 beat/cycle.
- m_axis_tvalid_o and m_axis_tdata_o/tlast_o hold stable while tvalid=1 and tready=0 (AXIS rule).
- push request = s_axis_tvalid_i. The beat is accepted if count < DEPTH, or if count == DEPTH and a pop occurs in the same cycle.
- Simultaneous push and pop leaves count unchanged. This holds at full and when count==1, where the output register is refilled from the just-written beat without a bubble.
- A push request that is not accepted drops the beat and sets overflow_o=1. overflow_o is cleared only by rst_i.
  - A dropped tlast beat is lost. The frame then merges with the next frame; this is accepted, and overflow_o flags it.
- Occupancy counts every beat not yet popped, including the beat held in the output register. level_o = count, registered, updated the edge after the push/pop.
- s_afull_o = (count >= AFULL_LVL), registered alongside level_o.
- frames_o increments by 1 on each pop with m_axis_tlast_o=1.
- Control is a 2-state output FSM:
  - EMPTY: m_axis_tvalid_o=0. EMPTY->VALID when an entry becomes available.
  - VALID: m_axis_tvalid_o=1. VALID->EMPTY on a pop when no further entry exists and no push occurs this cycle.
- Input beats with s_axis_tvalid_i=0 are ignored regardless of tdata/tlast values.

Test Plan:
- Reset then 4 beats 0x10,0x11,0x12,0x13 (last on 0x13), tready=1 -> output 0x10..0x13 one per cycle, first valid 1 cycle after first input. tlast only on 0x13; frames_o=1; level_o returns to 0.
- tready=0, push 16 beats 0x00..0x0F -> level_o=16. s_afull_o asserts one cycle after the 12th beat. m_axis_tdata_o holds 0x00. overflow_o=0.
- From full with tready=0, push 0xAA -> beat dropped, overflow_o=1 and stays 1. Then tready=1 -> exactly 0x00..0x0F are output; 0xAA never appears.
- Full FIFO, tready=1 and continuous input 0x20.. -> level_o stays 16, no drops, overflow_o=0. Output order is 0x00..0x0F, 0x20, 0x21, ...
- Random tready (50%) over 3 frames of 64 beats from the filter model -> output sequence equals input sequence, tlast positions preserved, frames_o=3. tdata/tlast stable whenever tvalid=1 and tready=0.
- Assert rst_i for 1 cycle while level_o=7 and mid-frame -> next cycle m_axis_tvalid_o=0, level_o=0, frames_o=0, overflow_o=0. A new frame after reset passes cleanly.
